mux_scan_scheduler: RTL and testbench
=====================================

// Module: mux_scan_scheduler
// PURPOSE
//   Shares the 4:1 channel MUX (2-bit select, N+1-bit data) between four
//   requesters in the fire-fighting machine controller (sensor/actuator channels).
//   Round-robin arbiter plus sequencer: grants one channel, drives the MUX select,
//   waits for the selected path to settle, registers the MUX output with a valid
//   strobe, holds the grant for a bounded time, then releases.
// PARAMETERS
//   N          10  MSB index of data path; data width is N+1 (same as MUX)
//   SETTLE_CYC 2   cycles from select change to capture; legal 1..255
//   HOLD_CYC   4   cycles grant is held after capture; legal 1..255
// PORTS
//   clk        in   1    system clock, all state on rising edge
//   rst_n      in   1    asynchronous, active-low reset
//   req        in   4    request per channel; bit i = MUX input i+1 (sel=i)
//   mux_y      in   N+1  MUX output Y
//   seleccion  out  2    drives MUX select
//   gnt        out  4    one-hot grant, 0 when idle
//   dato       out  N+1  captured MUX data
//   dato_valid out  1    one-cycle strobe, dato newly captured
//   busy       out  1    1 whenever state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, seleccion=2'b00, gnt=0, dato=0,
//     dato_valid=0, busy=0, round-robin pointer last=3 (ch0 wins first).
//   Counter: 8-bit, shared by SETTLE and HOLD.
//   States: IDLE -> SETTLE -> HOLD -> IDLE (capture is the SETTLE->HOLD edge).
//   IDLE: at edge E with req!=0, winner = first set bit scanning last+1, last+2,
//     ... (mod 4). At E: seleccion=winner, gnt=1<<winner, busy=1, cnt=SETTLE_CYC-1,
//     state=SETTLE. req=0 -> stay IDLE, outputs unchanged.
//   SETTLE: per edge, if req[winner]=0 -> abort (see below); else if cnt=0 ->
//     dato<=mux_y, dato_valid=1 for the next cycle only, cnt=HOLD_CYC-1,
//     state=HOLD; else cnt-1. Capture edge = E+SETTLE_CYC.
//   HOLD: per edge, if req[winner]=0 or cnt=0 -> release; else cnt-1.
//     Full-length release edge = E+SETTLE_CYC+HOLD_CYC.
//   Release/abort edge R: gnt=0, busy=0, last=winner, state=IDLE. Abort in SETTLE:
//     no capture, dato unchanged, no dato_valid.
//   Next grant earliest at R+1 (one idle cycle between grants, gnt never
//     switches directly between channels). Period per full grant =
//     SETTLE_CYC+HOLD_CYC+1 cycles.
//   seleccion changes only at grant edges; holds last winner while IDLE.
//   No preemption: other req bits ignored while busy; they are only sampled
//     in IDLE. req change in same cycle as release: new req seen at R+1.
//   dato_valid never high in two consecutive cycles; dato stable otherwise.
//   Reset mid-grant: all outputs return to reset values immediately; pointer=3.
//   gnt is always 0 or one-hot; gnt!=0 iff busy.
// TESTING
//   1 Reset, req=4'b0001, mux_y=11'h155, SETTLE=2,HOLD=4 -> gnt=0001 at E,
//     dato=155 and dato_valid at E+2 (one cycle), gnt=0 at E+6.
//   2 req=4'b1111 held continuously -> grants 0,1,2,3,0 in order, each grant
//     7 cycles apart, seleccion matches grant index every time.
//   3 After ch2 served, req=4'b0101 -> ch0 next (wrap-around past 3), not ch2.
//   4 req[1] dropped 1 cycle after grant (in SETTLE) -> gnt=0 next edge,
//     no dato_valid, dato keeps previous value; pointer advances to 1.
//   5 req[3] dropped during HOLD -> release same edge, dato_valid already seen
//     once; new req[0] granted exactly one cycle later.
//   6 rst_n pulsed low mid-SETTLE (asynchronous, between edges) ->
//     gnt=0, seleccion=0, dato=0, busy=0 immediately; req=4'b1000 then gets ch3.

Source files
------------

// File: rtl/mux_scan_scheduler.sv
// Round-robin owner of the shared 4:1 channel MUX: grant, settle,
// capture with a one-cycle strobe, hold, release.
module mux_scan_scheduler #(
  parameter int N          = 10,
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_CYC   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [N:0]   mux_y,
  output logic [1:0]   seleccion,
  output logic [3:0]   gnt,
  output logic [N:0]   dato,
  output logic         dato_valid,
  output logic         busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [7:0] SET_LD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] HLD_LD = 8'(HOLD_CYC - 1);

  logic [1:0] state;
  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic [7:0] cnt;
  logic       keep;
  logic       rel;
  logic       cap;

  // scan starts just past the last served channel
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign keep = req[seleccion];

  always_comb begin
    rel = 1'b0;
    cap = 1'b0;
    unique case (1'b1)
      state == SETTLE: begin
        rel = !keep;
        cap = keep && (cnt == 8'd0);
      end
      state == HOLD: rel = !keep || (cnt == 8'd0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= 2'd3;
      cnt        <= 8'd0;
      seleccion  <= 2'd0;
      gnt        <= 4'd0;
      dato       <= '0;
      dato_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dato_valid <= 1'b0;
      if (rel) begin
        state <= IDLE;
        gnt   <= 4'd0;
        busy  <= 1'b0;
        last  <= seleccion;
      end else if (cap) begin
        dato       <= mux_y;
        dato_valid <= 1'b1;
        cnt        <= HLD_LD;
        state      <= HOLD;
      end else begin
        case (state)
          IDLE: begin
            if (req != 4'd0) begin
              seleccion <= winner;
              gnt       <= 4'b0001 << winner;
              busy      <= 1'b1;
              cnt       <= SET_LD;
              state     <= SETTLE;
            end
          end
          SETTLE, HOLD: cnt <= cnt - 8'd1;
          default: begin
            state <= IDLE;
            gnt   <= 4'd0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_scheduler.sv
// Scoreboard bench: transaction-age reference model feeds a queue,
// a monitor compares every cycle.
module tb_mux_scan_scheduler;

  localparam int N = 10;
  localparam int S = 2;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = 4'd0;
  logic [N:0]   mux_y = '0;
  logic [1:0]   seleccion;
  logic [3:0]   gnt;
  logic [N:0]   dato;
  logic         dato_valid;
  logic         busy;

  mux_scan_scheduler #(.N(N), .SETTLE_CYC(S), .HOLD_CYC(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mux_y      (mux_y),
    .seleccion  (seleccion),
    .gnt        (gnt),
    .dato       (dato),
    .dato_valid (dato_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] gnt;
    logic [N:0] dato;
    logic       dv;
    logic       busy;
  } obs_t;

  obs_t q[$];
  int total = 0;
  int bad = 0;

  int         m_owner = -1;
  int         m_start = 0;
  int         m_last = 3;
  int         n = 0;
  logic [1:0] m_sel = 2'd0;
  logic [N:0] m_dato = '0;
  logic       m_dv = 1'b0;

  function automatic obs_t actual();
    obs_t o;
    o.sel  = seleccion;
    o.gnt  = gnt;
    o.dato = dato;
    o.dv   = dato_valid;
    o.busy = busy;
    return o;
  endfunction

  function automatic obs_t expected();
    obs_t o;
    o.sel  = m_sel;
    o.gnt  = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
    o.dato = m_dato;
    o.dv   = m_dv;
    o.busy = (m_owner >= 0);
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got sel=%0d gnt=%b dato=%h dv=%b busy=%b want sel=%0d gnt=%b dato=%h dv=%b busy=%b",
               name, $time, got.sel, got.gnt, got.dato, got.dv, got.busy,
               exp.sel, exp.gnt, exp.dato, exp.dv, exp.busy);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 2'd0;
    m_dato  = '0;
    m_dv    = 1'b0;
  endtask

  // Behaviour described by edges elapsed since the grant edge
  task automatic model_edge(input logic [3:0] r, input logic [N:0] y);
    m_dv = 1'b0;
    n++;
    if (m_owner < 0) begin
      if (r != 4'd0) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (m_owner < 0 && r[c]) m_owner = c;
        end
        m_start = n;
        m_sel   = 2'(m_owner);
      end
    end else begin
      int age;
      age = n - m_start;
      if (!r[m_owner] || age == S + H) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (age == S) begin
        m_dato = y;
        m_dv   = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [N:0] y);
    @(negedge clk);
    req   = r;
    mux_y = y;
    model_edge(r, y);
    q.push_back(expected());
  endtask

  task automatic steps(input logic [3:0] r, input int cnt);
    for (int i = 0; i < cnt; i++) step(r, (N+1)'($urandom));
  endtask

  task automatic pulse_reset();
    obs_t z;
    z = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = 4'd0;
    #1;
    check("async_reset", actual(), z);
    @(negedge clk);
    check("reset_hold", actual(), z);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) check("cycle", actual(), q.pop_front());
    end
  end

  initial begin
    logic [3:0] cur;
    obs_t z;
    z = '0;
    #1;
    check("reset", actual(), z);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) step(4'b0001, 11'h155);
    steps(4'b0000, 2);

    pulse_reset();
    steps(4'b1111, 35);
    steps(4'b0000, 2);

    steps(4'b0100, 7);
    steps(4'b0101, 8);
    steps(4'b0000, 2);

    steps(4'b0010, 1);
    steps(4'b0000, 3);

    steps(4'b1000, 4);
    steps(4'b0001, 8);
    steps(4'b0000, 2);

    steps(4'b0010, 2);
    pulse_reset();
    steps(4'b1000, 8);

    cur = 4'd0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) cur = 4'($urandom);
      step(cur, (N+1)'($urandom));
      if (i == 1000) pulse_reset();
    end

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
